// File: rtl/spi_xfer32_if.sv
// spi_xfer32_if: command/response bundle between the flash controller and
// the spi_xfer32 shift engine. The controller drives the master modport, the
// engine takes the slave modport.
interface spi_xfer32_if;
  logic        read;
  logic        write;
  logic [31:0] din;
  logic [1:0]  nbytes;
  logic [31:0] dout;
  logic        busy;

  modport master (
    output read,
    output write,
    output din,
    output nbytes,
    input  dout,
    input  busy
  );

  modport slave (
    input  read,
    input  write,
    input  din,
    input  nbytes,
    output dout,
    output busy
  );
endinterface

// File: rtl/spi_xfer32.sv
// spi_xfer32: mode-0 SPI master shift engine. Sends up to four bytes MSB-first
// from a left-justified command word, captures the full-duplex receive
// stream, and reports progress through a single busy flag.
// Optional build macro: SPI_LOOPBACK_EN -- when defined the receive path
// samples the internal sdo instead of the sdi pin (bring-up without a flash).
module spi_xfer32 #(
  parameter int CLK_DIV = 2
) (
  input  logic         clk,
  input  logic         reset,
  spi_xfer32_if.slave  bus,
  input  logic         sdi,
  output logic         sdo,
  output logic         clk_out,
  output logic         cs
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [4:0]  bit_r, bit_s;
  logic [31:0] tx_r, tx_s;
  logic [31:0] rx_r, rx_s;
  logic [1:0]  nbytes_r, nbytes_s;
  logic        op_read_r, op_read_s;
  logic        busy_r, busy_s;
  logic        cs_r, cs_s;
  logic        sck_r, sck_s;
  logic        sdo_r, sdo_s;
  logic [31:0] dout_r, dout_s;
  logic        phase_done_s;
  logic        last_bit_s;
  logic        sample_s;

  // Receive source: internal MOSI in loopback builds, MISO pin otherwise.
`ifdef SPI_LOOPBACK_EN
  assign sample_s = sdo_r;
`else
  assign sample_s = sdi;
`endif

  assign phase_done_s = (cnt_r == DIV_LAST);
  // Index of the final bit is 8*(nbytes+1)-1.
  assign last_bit_s   = (bit_r == {nbytes_r, 3'b111});

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_s     = bit_r;
    tx_s      = tx_r;
    rx_s      = rx_r;
    nbytes_s  = nbytes_r;
    op_read_s = op_read_r;
    busy_s    = busy_r;
    cs_s      = cs_r;
    sck_s     = sck_r;
    sdo_s     = sdo_r;
    dout_s    = dout_r;

    case (state_r)
      IDLE: begin
        cnt_s = 8'd0;
        if (bus.read ^ bus.write) begin
          state_s   = SETUP;
          bit_s     = 5'd0;
          tx_s      = bus.din;
          rx_s      = 32'd0;
          nbytes_s  = bus.nbytes;
          op_read_s = bus.read;
          busy_s    = 1'b1;
          cs_s      = 1'b0;
          sck_s     = 1'b0;
          sdo_s     = bus.din[31];
        end else begin
          busy_s = 1'b0;
          cs_s   = 1'b1;
          sck_s  = 1'b0;
          sdo_s  = 1'b0;
        end
      end

      SETUP, LOW: begin
        if (phase_done_s) begin
          state_s = HIGH;
          cnt_s   = 8'd0;
          sck_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end

      HIGH: begin
        // Capture at the first cycle after the rising SCK edge.
        if (cnt_r == 8'd0) begin
          rx_s = {rx_r[30:0], sample_s};
        end else begin
          rx_s = rx_r;
        end
        if (phase_done_s) begin
          cnt_s = 8'd0;
          sck_s = 1'b0;
          if (last_bit_s) begin
            state_s = HOLD;
          end else begin
            state_s = LOW;
            bit_s   = bit_r + 5'd1;
            tx_s    = {tx_r[30:0], 1'b0};
            sdo_s   = tx_r[30];
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end

      HOLD: begin
        if (phase_done_s) begin
          state_s = GAP;
          cnt_s   = 8'd0;
          cs_s    = 1'b1;
          sdo_s   = 1'b0;
          if (op_read_r) begin
            // rx was cleared at start, so unused upper bits are already zero.
            dout_s = rx_r;
          end else begin
            dout_s = dout_r;
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end

      GAP: begin
        if (phase_done_s) begin
          state_s = IDLE;
          cnt_s   = 8'd0;
          busy_s  = 1'b0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end

      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
        busy_s  = 1'b0;
        cs_s    = 1'b1;
        sck_s   = 1'b0;
        sdo_s   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      bit_r     <= 5'd0;
      tx_r      <= 32'd0;
      rx_r      <= 32'd0;
      nbytes_r  <= 2'd0;
      op_read_r <= 1'b0;
      busy_r    <= 1'b0;
      cs_r      <= 1'b1;
      sck_r     <= 1'b0;
      sdo_r     <= 1'b0;
      dout_r    <= 32'd0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_r     <= bit_s;
      tx_r      <= tx_s;
      rx_r      <= rx_s;
      nbytes_r  <= nbytes_s;
      op_read_r <= op_read_s;
      busy_r    <= busy_s;
      cs_r      <= cs_s;
      sck_r     <= sck_s;
      sdo_r     <= sdo_s;
      dout_r    <= dout_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.dout = dout_r;
  assign cs       = cs_r;
  assign clk_out  = sck_r;
  assign sdo      = sdo_r;

endmodule

// File: doc/spi_xfer32.md
# spi_xfer32

SPI master shift engine sitting directly downstream of the flash control peripheral. It accepts a command word of up to 32 bits with a byte count, serialises it MSB-first on a mode-0 SPI bus, and captures the full-duplex receive stream. It reports completion through a single busy flag, which the controller polls between command phases.

## Interface

Parameters:
- CLK_DIV, default 2: SPI half-period in clk cycles; legal range 1..255.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- read  input  1  start request; capture received bits into dout.
- write  input  1  start request; dout is left unchanged.
- din  input  32  transmit word; byte 3 (din[31:24]) is sent first.
- nbytes  input  2  bytes to transfer, minus one (0 = 1 byte, 3 = 4 bytes).
- dout  output  32  received data, right-aligned.
- busy  output  1  transaction in progress.
- sdi  input  1  SPI MISO.
- sdo  output  1  SPI MOSI.
- clk_out  output  1  SPI SCK; idles low.
- cs  output  1  SPI chip select; active low.

## Operation

- States: IDLE, SETUP, LOW, HIGH, HOLD, GAP.
- IDLE:
  - Exactly one of read or write high: latch din, nbytes and the op type, then go to SETUP.
  - Both high, or neither: stay in IDLE.
  - Requests are level-sensitive. A request still held when the block returns to IDLE starts a new transaction.
  - Requests in any other state are ignored.
- Shift register:
  - Latched word is left-justified. Transmit length is bits = 8*(nbytes+1), taken from din[31] downward.
  - Unused low bytes of din are never sent.
- SETUP: cs=0, sdo=first bit, clk_out=0, for CLK_DIV cycles. This is the low phase of bit 0. Then go to HIGH.
- HIGH:
  - clk_out=1 for CLK_DIV cycles.
  - sdi is sampled in the first cycle of HIGH (the rising edge) and shifted into the receive register.
  - At the end of HIGH: if this was the last bit, go to HOLD. Otherwise shift sdo to the next bit and go to LOW.
- LOW: clk_out=0 for CLK_DIV cycles, then go to HIGH.
- HOLD:
  - clk_out=0, cs=0, sdo holds the last bit, for CLK_DIV cycles.
  - On exit: cs=1 and sdo=0.
  - If the op is read, dout is loaded with the receive register, right-aligned, with upper unused bits zero.
  - Then go to GAP.
- GAP: cs=1, busy=1 for CLK_DIV cycles (minimum cs-high time), then go to IDLE.
- A write never modifies dout. dout holds its value until the next completed read.

## Timing

- Reset values: busy=0, cs=1, clk_out=0, sdo=0, dout=0. The state goes to IDLE and all counters clear.
- Reset asserted mid-transaction aborts it the next clk edge:
  - cs rises immediately.
  - dout keeps its reset value of 0; no partial data is loaded.
- Start latency: request seen in IDLE at edge N, so busy=1 and cs=0 from edge N+1.
- busy stays high for exactly (2*bits+2)*CLK_DIV cycles, then returns to 0 in IDLE.
  - CLK_DIV=2, nbytes=0: 36 cycles.
  - CLK_DIV=2, nbytes=3: 132 cycles.
- clk_out produces exactly `bits` rising edges per transaction, with 50% duty cycle.
- sdo changes only on the clk_out falling edge (entry to LOW) or when cs changes.
- dout is valid in the same cycle busy falls, and stays stable while busy=0.
- The upstream controller may pulse read/write for one cycle. busy rising one cycle later is guaranteed, so the controller can wait for busy=1 and then busy=0.

## Configuration

- SPI_LOOPBACK_EN:
  - Defined: the sdi pin is ignored. The receive path samples the internal sdo at the clk_out rising edge, so a read returns the transmitted bytes right-aligned. This is for bring-up without a flash part.
  - Undefined (production): the receive path samples the sdi pin.
  - All timing and other outputs are identical either way.

## Test plan

- Reset: after reset, busy=0, cs=1, clk_out=0, sdo=0, dout=0. Apply reset during bit 5 of a transfer: next edge cs=1, busy=0, dout=0.
- Write-enable: write=1 for one cycle, din=32'h0600_0000, nbytes=0, CLK_DIV=2.
  - sdo shows 00000110 over 8 clk_out rises.
  - busy high for 36 cycles; dout unchanged.
- Read: read pulse, din=32'h0301_2300, nbytes=3, flash model drives byte 8'hA5 during the 4th byte.
  - 32 clk_out rises; busy high for 132 cycles.
  - dout[7:0]=8'hA5 and dout[31:8] equals bits returned in bytes 0..2.
- Ignored requests:
  - read and write both high in IDLE: no transaction starts.
  - Pulse write while busy: no effect. Transfer count and timing are unchanged.
- Back-to-back: hold write high continuously. A second transaction starts the cycle after the first GAP ends. cs stays high for at least CLK_DIV cycles between the two.
- Loopback (SPI_LOOPBACK_EN defined): read with din=32'hDEAD_BEEF and nbytes=3 gives dout=32'hDEADBEEF. With nbytes=1 it gives dout=32'h0000DEAD.
